// File: rtl/df_stream_sink_pkg.sv
// Shared definitions for the dataflow stream sink: FSM state encoding and
// default geometry, reused by other dataflow sinks and sources.
package df_stream_sink_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_N     = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_CNT_W = 16;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/df_stream_sink_if.sv
// Token strobe/data from the upstream operator plus the valid/ready read port
// toward the host; the sink uses the slave view.
interface df_stream_sink_if #(
  parameter int unsigned N = 16
);

  logic         R_IN;
  logic [N-1:0] D_IN;
  logic         RD_VALID;
  logic [N-1:0] RD_DATA;
  logic         RD_READY;

  modport master (
    output R_IN,
    output D_IN,
    output RD_READY,
    input  RD_VALID,
    input  RD_DATA
  );

  modport slave (
    input  R_IN,
    input  D_IN,
    input  RD_READY,
    output RD_VALID,
    output RD_DATA
  );

endinterface

// File: rtl/df_sync_fifo.sv
// First-word fall-through synchronous FIFO with exact occupancy. A pop on a
// full FIFO frees its slot for a push in the same cycle.
module df_sync_fifo #(
  parameter  int unsigned N     = 16,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [N-1:0]  din,
  input  logic          pop,
  output logic [N-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  // Popping an empty FIFO is silently ignored.
  assign do_pop = pop & ~empty;
  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);

  // Head is gated so the read port shows zero whenever nothing is held.
  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy lives in level/pointers,
  // so stale words are never observable and the array can map to plain RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Callers must only push into a full FIFO when the head leaves this cycle.
  property p_no_overrun;
    @(posedge CLK) disable iff (RST) (push && full) |-> do_pop;
  endproperty
  a_no_overrun: assert property (p_no_overrun);

endmodule

// File: rtl/df_stream_sink.sv
// Terminal consumer for R/D tokens: buffers accepted tokens in a FWFT FIFO,
// counts them against a programmed total and flags drops on overrun.
module df_stream_sink
  import df_stream_sink_pkg::*;
#(
  parameter  int unsigned N     = DEF_N,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  parameter  int unsigned CNT_W = DEF_CNT_W,
  localparam int unsigned LW    = level_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic [CNT_W-1:0]  EXPECT,
  df_stream_sink_if.slave   strm,
  output logic [CNT_W-1:0]  COUNT,
  output logic [LW-1:0]     LEVEL,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] expect_q;
  logic             overflow_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             offered;
  logic             accept;
  logic             drop;
  logic             arm;
  logic             reach;

  // Tokens only matter while a run is active; IDLE and DONE ignore R_IN.
  assign offered = (state_q == S_RUN) & EN & strm.R_IN;

  // When full, the head leaving this cycle frees the slot for the newcomer.
  assign accept  = offered & (~fifo_full | strm.RD_READY);
  assign drop    = offered & ~accept;

  // START re-arms from IDLE or DONE; a run in progress cannot be restarted.
  assign arm       = START & (state_q != S_RUN);
  assign count_inc = count_q + CNT_W'(1);
  assign reach     = accept & (count_inc == expect_q);

  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d = (EXPECT == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (reach) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q    <= '0;
      expect_q   <= '0;
      overflow_q <= 1'b0;
    end else if (arm) begin
      count_q    <= '0;
      expect_q   <= EXPECT;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= count_inc;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  df_sync_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (accept),
    .din   (strm.D_IN),
    .pop   (strm.RD_READY),
    .dout  (strm.RD_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (LEVEL)
  );

  assign strm.RD_VALID = ~fifo_empty;
  assign COUNT         = count_q;
  assign BUSY          = (state_q == S_RUN);
  assign DONE          = (state_q == S_DONE);
  assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_df_stream_sink.sv
// Self-checking bench for df_stream_sink: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_df_stream_sink;

  localparam int unsigned N     = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic             CLK = 1'b0;
  logic             RST;
  logic             EN;
  logic             START;
  logic [CNT_W-1:0] EXPECT;
  logic [CNT_W-1:0] COUNT;
  logic [LW-1:0]    LEVEL;
  logic             BUSY;
  logic             DONE;
  logic             OVERFLOW;

  df_stream_sink_if #(.N(N)) sif ();

  df_stream_sink #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .START    (START),
    .EXPECT   (EXPECT),
    .strm     (sif),
    .COUNT    (COUNT),
    .LEVEL    (LEVEL),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: tokens in a queue, run status as plain flags.
  logic [N-1:0] q_m [$];
  int unsigned  cnt_m;
  int unsigned  exp_m;
  bit           running_m;
  bit           done_m;
  bit           ovf_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    cnt_m     = 0;
    exp_m     = 0;
    running_m = 0;
    done_m    = 0;
    ovf_m     = 0;
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, compare.
  task automatic step(input bit rst, input bit en, input bit rin, input logic [N-1:0] d,
                      input bit rdy, input bit st, input logic [CNT_W-1:0] ex);
    bit pop, offer, acc, was_running;
    RST          = rst;
    EN           = en;
    sif.R_IN     = rin;
    sif.D_IN     = d;
    sif.RD_READY = rdy;
    START        = st;
    EXPECT       = ex;
    @(posedge CLK);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      was_running = running_m;
      pop   = rdy && (q_m.size() != 0);
      offer = running_m && en && rin;
      acc   = offer && ((q_m.size() < DEPTH) || pop);
      if (pop) void'(q_m.pop_front());
      if (acc) begin
        q_m.push_back(d);
        cnt_m = (cnt_m + 1) % (1 << CNT_W);
        if (cnt_m == exp_m) begin
          running_m = 0;
          done_m    = 1;
        end
      end else if (offer) begin
        ovf_m = 1;
      end
      if (st && !was_running) begin
        cnt_m     = 0;
        ovf_m     = 0;
        exp_m     = ex;
        running_m = (ex != 0);
        done_m    = (ex == 0);
      end
    end
    check("level", 32'(LEVEL), 32'(q_m.size()));
    check("rd_valid", 32'(sif.RD_VALID), 32'(q_m.size() != 0));
    if (q_m.size() != 0) check("rd_data", 32'(sif.RD_DATA), 32'(q_m[0]));
    check("count", 32'(COUNT), 32'(cnt_m));
    check("busy", 32'(BUSY), 32'(running_m));
    check("done", 32'(DONE), 32'(done_m));
    check("overflow", 32'(OVERFLOW), 32'(ovf_m));
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, 0, '0, rdy, 0, '0);
  endtask

  task automatic arm(input logic [CNT_W-1:0] ex);
    step(0, 1, 0, '0, 0, 1, ex);
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, '0, 0, 0, '0);
    check("rst_rd_data", 32'(sif.RD_DATA), 32'h0);
    check("rst_level", 32'(LEVEL), 32'h0);

    // Three tokens with the host draining every cycle.
    arm(16'd3);
    step(0, 1, 1, 16'h0011, 1, 0, '0);
    check("t1_tok0", 32'(sif.RD_DATA), 32'h0011);
    step(0, 1, 1, 16'h0022, 1, 0, '0);
    check("t1_tok1", 32'(sif.RD_DATA), 32'h0022);
    step(0, 1, 1, 16'h0033, 1, 0, '0);
    check("t1_tok2", 32'(sif.RD_DATA), 32'h0033);
    check("t1_done", 32'(DONE), 32'h1);
    check("t1_count", 32'(COUNT), 32'd3);
    check("t1_ovf", 32'(OVERFLOW), 32'h0);
    idle_cycles(2, 1);

    // Overrun: 20 tokens into a 16-deep FIFO with no draining.
    arm(16'd20);
    for (int i = 0; i < 20; i++) step(0, 1, 1, N'($urandom), 0, 0, '0);
    check("t2_level", 32'(LEVEL), 32'd16);
    check("t2_count", 32'(COUNT), 32'd16);
    check("t2_ovf", 32'(OVERFLOW), 32'h1);
    check("t2_busy", 32'(BUSY), 32'h1);

    // Pop-when-full frees the slot for a simultaneous token.
    step(0, 1, 1, 16'hBEEF, 1, 0, '0);
    check("t3_level", 32'(LEVEL), 32'd16);
    check("t3_count", 32'(COUNT), 32'd17);
    check("t3_ovf", 32'(OVERFLOW), 32'h1);
    idle_cycles(18, 1);

    // EN low masks tokens; START mid-run is ignored.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h5555, 0, 0, '0);
    check("t4_count_hold", 32'(COUNT), 32'd17);
    check("t4_level_hold", 32'(LEVEL), 32'd0);
    step(0, 1, 1, 16'h1234, 0, 0, '0);
    check("t4_count_inc", 32'(COUNT), 32'd18);
    step(0, 1, 0, '0, 0, 1, 16'd2);
    check("t5_start_ignored", 32'(COUNT), 32'd18);
    step(0, 1, 1, 16'h0001, 0, 0, '0);
    step(0, 1, 1, 16'h0002, 0, 0, '0);
    check("t4_done", 32'(DONE), 32'h1);

    // EXPECT = 0 goes straight to DONE; FIFO contents survive re-arm.
    arm(16'd0);
    check("t5_done", 32'(DONE), 32'h1);
    check("t5_busy", 32'(BUSY), 32'h0);
    check("t5_level_kept", 32'(LEVEL), 32'd3);
    idle_cycles(4, 1);

    // Reset mid-run with five tokens held.
    arm(16'd10);
    for (int i = 0; i < 5; i++) step(0, 1, 1, N'($urandom), 0, 0, '0);
    check("t6_pre_level", 32'(LEVEL), 32'd5);
    step(1, 1, 1, 16'hAAAA, 0, 0, '0);
    check("t6_level", 32'(LEVEL), 32'd0);
    check("t6_count", 32'(COUNT), 32'd0);
    check("t6_valid", 32'(sif.RD_VALID), 32'h0);
    check("t6_busy", 32'(BUSY), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 6),
           N'($urandom),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 14) == 0),
           CNT_W'($urandom_range(0, 24)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
